imm_ext_unit: RTL and testbench

IMM_EXT_UNIT -- requirements
Module: imm_ext_unit

---
 rtl/imm_ext_pkg.sv | 25 ++
 rtl/imm_field_extend.sv | 110 +++++++++++
 rtl/imm_ext_unit.sv | 181 ++++++++++++++++++
 tb/tb_imm_ext_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
// Shared types and default sizes for the immediate extension unit.
//   - immMode_e  : extension mode carried on the 'mode' port
//   - extState_e : prefix-tracking FSM state
//   - IMM_IN_W_DEF / IMM_OUT_W_DEF : default raw-field and datapath widths
// -----------------------------------------------------------------------------
package imm_ext_pkg;

   localparam int IMM_IN_W_DEF  = 11;
   localparam int IMM_OUT_W_DEF = 16;

   typedef enum logic [1:0] {
      MODE_ZE      = 2'd0,
      MODE_SE      = 2'd1,
      MODE_SE_SHL1 = 2'd2,
      MODE_PREFIX  = 2'd3
   } immMode_e;

   typedef enum logic {
      ST_IDLE        = 1'b0,
      ST_HAVE_PREFIX = 1'b1
   } extState_e;

endpackage

// File: rtl/imm_field_extend.sv
// -----------------------------------------------------------------------------
// imm_field_extend
// Purely combinational masking / concatenation / extension of an immediate.
// Ports:
//   i_field      raw field, right-aligned
//   i_len        field length in bits (values above IN_W are clamped)
//   i_mode       extension mode (PREFIX is treated like ZE here)
//   i_hasPrefix  a stored prefix is to be concatenated above the field
//   i_prefix     stored prefix (already masked)
//   i_prefixLen  stored prefix length (already clamped)
//   o_fieldMask  field with bits at and above the clamped length cleared
//   o_lenClamp   clamped field length
//   o_value      extended result, OUT_W bits
//   o_ovf        combined length exceeded OUT_W
// -----------------------------------------------------------------------------
module imm_field_extend
   import imm_ext_pkg::*;
#(
   parameter  int IN_W  = IMM_IN_W_DEF,
   parameter  int OUT_W = IMM_OUT_W_DEF,
   localparam int LEN_W = $clog2(IN_W + 1)
) (
   input  logic [IN_W-1:0]  i_field,
   input  logic [LEN_W-1:0] i_len,
   input  immMode_e         i_mode,
   input  logic             i_hasPrefix,
   input  logic [IN_W-1:0]  i_prefix,
   input  logic [LEN_W-1:0] i_prefixLen,
   output logic [IN_W-1:0]  o_fieldMask,
   output logic [LEN_W-1:0] o_lenClamp,
   output logic [OUT_W-1:0] o_value,
   output logic             o_ovf
);

   // The concatenated value must hold two full fields and also be at least as
   // wide as the datapath so the extension loops never index past its end.
   localparam int CMB_W = ((2 * IN_W) > OUT_W) ? (2 * IN_W) : OUT_W;
   localparam int CL_W  = $clog2(CMB_W + 1);

   logic [LEN_W-1:0] w_lenClamp;
   logic [IN_W-1:0]  w_fieldMask;
   logic [CMB_W-1:0] w_cmb;
   logic [CL_W-1:0]  w_cmbLen;
   logic             w_sign;
   logic [OUT_W-1:0] w_ext;
   logic             w_seMode;

   assign w_seMode    = (i_mode == MODE_SE) || (i_mode == MODE_SE_SHL1);
   assign o_fieldMask = w_fieldMask;
   assign o_lenClamp  = w_lenClamp;

   always_comb begin
      w_lenClamp = (int'(i_len) > IN_W) ? LEN_W'(IN_W) : i_len;
   end

   always_comb begin
      w_fieldMask = '0;
      for (int i = 0; i < IN_W; i++) begin
         if (i < int'(w_lenClamp)) begin
            w_fieldMask[i] = i_field[i];
         end
      end
   end

   // Prefix sits directly above the field; lengths add.
   always_comb begin
      if (i_hasPrefix) begin
         w_cmb    = (CMB_W'(i_prefix) << w_lenClamp) | CMB_W'(w_fieldMask);
         w_cmbLen = CL_W'(i_prefixLen) + CL_W'(w_lenClamp);
      end else begin
         w_cmb    = CMB_W'(w_fieldMask);
         w_cmbLen = CL_W'(w_lenClamp);
      end
   end

   // Sign is the top bit of the combined value; a zero length has sign 0.
   always_comb begin
      w_sign = 1'b0;
      for (int i = 0; i < OUT_W; i++) begin
         if ((i + 1) == int'(w_cmbLen)) begin
            w_sign = w_cmb[i];
         end
      end
   end

   always_comb begin
      w_ext = '0;
      for (int i = 0; i < OUT_W; i++) begin
         if (i < int'(w_cmbLen)) begin
            w_ext[i] = w_cmb[i];
         end else if (w_seMode) begin
            w_ext[i] = w_sign;
         end
      end
   end

   // On overflow the low OUT_W bits are returned untouched: no extension and
   // no SE_SHL1 shift is applied to a value that already fills the datapath.
   always_comb begin
      o_value = w_ext;
      o_ovf   = 1'b0;
      if (int'(w_cmbLen) > OUT_W) begin
         o_value = w_cmb[OUT_W-1:0];
         o_ovf   = 1'b1;
      end else if (i_mode == MODE_SE_SHL1) begin
         o_value = w_ext << 1;
      end
   end

endmodule

// File: rtl/imm_ext_unit.sv
// -----------------------------------------------------------------------------
// imm_ext_unit
// Immediate extension unit with optional PREFIX concatenation and a
// valid/ready handshake on both sides; result latency is one cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input beat handshake
//   imm_in, imm_len     raw right-aligned field and its length
//   mode                ZE=0, SE=1, SE_SHL1=2, PREFIX=3
//   out_valid/out_ready output handshake
//   imm_out, ovf        extended result and overflow flag
// Build option: IMM_EXT_SKID_EN adds a one-entry skid buffer so that in_ready
// is driven straight from a flop with no path from out_ready.
// -----------------------------------------------------------------------------
module imm_ext_unit
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W_DEF,
   parameter int OUT_W = IMM_OUT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_W-1:0]            imm_in,
   input  logic [$clog2(IN_W+1)-1:0]  imm_len,
   input  logic [1:0]                 mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           imm_out,
   output logic                       ovf
);

   localparam int LEN_W = $clog2(IN_W + 1);

   extState_e        r_state;
   extState_e        w_stateNext;
   logic [IN_W-1:0]  r_prefix;
   logic [LEN_W-1:0] r_prefixLen;

   logic             w_accept;
   logic             w_isPrefix;
   logic             w_load;
   logic             w_hasPrefix;
   logic [IN_W-1:0]  w_fieldMask;
   logic [LEN_W-1:0] w_lenClamp;
   logic [OUT_W-1:0] w_value;
   logic             w_ovf;

   logic             r_outValid;
   logic [OUT_W-1:0] r_immOut;
   logic             r_ovf;

   assign w_isPrefix  = (immMode_e'(mode) == MODE_PREFIX);
   assign w_accept    = in_valid && in_ready;
   assign w_load      = w_accept && !w_isPrefix;
   assign w_hasPrefix = (r_state == ST_HAVE_PREFIX);

   assign out_valid = r_outValid;
   assign imm_out   = r_immOut;
   assign ovf       = r_ovf;

   imm_field_extend #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_ext (
      .i_field     (imm_in),
      .i_len       (imm_len),
      .i_mode      (immMode_e'(mode)),
      .i_hasPrefix (w_hasPrefix),
      .i_prefix    (r_prefix),
      .i_prefixLen (r_prefixLen),
      .o_fieldMask (w_fieldMask),
      .o_lenClamp  (w_lenClamp),
      .o_value     (w_value),
      .o_ovf       (w_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Any accepted PREFIX beat (re)arms HAVE_PREFIX; any other accepted beat
   // consumes the prefix and returns to IDLE.
   always_comb begin
      w_stateNext = r_state;
      if (w_accept) begin
         w_stateNext = w_isPrefix ? ST_HAVE_PREFIX : ST_IDLE;
      end
   end

   // The prefix is stored already masked and clamped, so the extender can
   // shift it into place without re-qualifying it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prefix    <= '0;
         r_prefixLen <= '0;
      end else if (w_accept) begin
         if (w_isPrefix) begin
            r_prefix    <= w_fieldMask;
            r_prefixLen <= w_lenClamp;
         end else begin
            r_prefix    <= '0;
            r_prefixLen <= '0;
         end
      end
   end

`ifdef IMM_EXT_SKID_EN

   // Skid slot holds one result produced while the output register was
   // stalled. in_ready is the flop r_skidEmpty, so the upstream never sees
   // out_ready combinationally.
   logic             r_skidEmpty;
   logic [OUT_W-1:0] r_skidVal;
   logic             r_skidOvf;
   logic             w_outFree;

   assign in_ready  = r_skidEmpty;
   assign w_outFree = !r_outValid || out_ready;

   // A waiting skid entry always moves to the output before anything new,
   // which keeps results in order; new results bypass the skid when the
   // output register is free this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outValid  <= 1'b0;
         r_immOut    <= '0;
         r_ovf       <= 1'b0;
         r_skidEmpty <= 1'b1;
         r_skidVal   <= '0;
         r_skidOvf   <= 1'b0;
      end else if (!r_skidEmpty) begin
         if (w_outFree) begin
            r_outValid  <= 1'b1;
            r_immOut    <= r_skidVal;
            r_ovf       <= r_skidOvf;
            r_skidEmpty <= 1'b1;
         end
      end else if (w_load) begin
         if (w_outFree) begin
            r_outValid <= 1'b1;
            r_immOut   <= w_value;
            r_ovf      <= w_ovf;
         end else begin
            r_skidVal   <= w_value;
            r_skidOvf   <= w_ovf;
            r_skidEmpty <= 1'b0;
         end
      end else if (out_ready) begin
         r_outValid <= 1'b0;
      end
   end

`else

   assign in_ready = !r_outValid || out_ready;

   // Loading a new result takes priority over draining, which gives
   // back-to-back transfers with no bubble when both happen on one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outValid <= 1'b0;
         r_immOut   <= '0;
         r_ovf      <= 1'b0;
      end else if (w_load) begin
         r_outValid <= 1'b1;
         r_immOut   <= w_value;
         r_ovf      <= w_ovf;
      end else if (out_ready) begin
         r_outValid <= 1'b0;
      end
   end

`endif

endmodule

// File: tb/tb_imm_ext_unit.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_unit
// Scoreboard bench for imm_ext_unit (IN_W=11, OUT_W=16). The driver pushes the
// expected result when a beat is accepted; a forked monitor pops and compares
// whenever a result is transferred, and checks results held under back-pressure.
// -----------------------------------------------------------------------------
module tb_imm_ext_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] imm_in;
   logic [3:0]  imm_len;
   logic [1:0]  mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] imm_out;
   logic        ovf;

   bit randReady = 1'b0;
   bit fixReady  = 1'b1;
   bit rndReady  = 1'b1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] val;
      bit          ov;
   } exp_t;
   exp_t expQ[$];

   // Reference model state: pending prefix value and length
   bit     mHave   = 1'b0;
   longint mPre    = 0;
   int     mPreLen = 0;

   typedef struct {
      logic [1:0]  m;
      logic [10:0] imm;
      logic [3:0]  len;
      logic [15:0] v;
      bit          o;
   } dir_t;

   dir_t dirTab [18] = '{
      '{2'd0, 11'h0FF,  4'd8,  16'h00FF, 1'b0},
      '{2'd1, 11'h080,  4'd8,  16'hFF80, 1'b0},
      '{2'd1, 11'h020,  4'd6,  16'hFFE0, 1'b0},
      '{2'd1, 11'h7FF,  4'd0,  16'h0000, 1'b0},
      '{2'd2, 11'h400,  4'd11, 16'hF800, 1'b0},
      '{2'd0, 11'h7FF,  4'd15, 16'h07FF, 1'b0},
      '{2'd1, 11'h400,  4'd15, 16'hFC00, 1'b0},
      '{2'd3, 11'h005,  4'd5,  16'h0000, 1'b0},
      '{2'd1, 11'h7FF,  4'd11, 16'h2FFF, 1'b0},
      '{2'd3, 11'h03F,  4'd6,  16'h0000, 1'b0},
      '{2'd1, 11'h7FF,  4'd11, 16'hFFFF, 1'b1},
      '{2'd3, 11'h001,  4'd3,  16'h0000, 1'b0},
      '{2'd3, 11'h002,  4'd2,  16'h0000, 1'b0},
      '{2'd1, 11'h003,  4'd2,  16'hFFFB, 1'b0},
      '{2'd3, 11'h7FF,  4'd11, 16'h0000, 1'b0},
      '{2'd2, 11'h01F,  4'd5,  16'hFFFE, 1'b0},
      '{2'd3, 11'h7FF,  4'd11, 16'h0000, 1'b0},
      '{2'd0, 11'h7FF,  4'd11, 16'hFFFF, 1'b1}
   };

   assign out_ready = randReady ? rndReady : fixReady;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      rndReady = ($urandom_range(0, 3) != 0);
   end

   imm_ext_unit #(
      .IN_W  (11),
      .OUT_W (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm_in    (imm_in),
      .imm_len   (imm_len),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .imm_out   (imm_out),
      .ovf       (ovf)
   );

   // Behavioural model: clamp, mask, concatenate, then extend with plain
   // integer arithmetic on 64-bit values.
   task automatic modelStep(input logic [1:0] m, input logic [10:0] imm,
                            input logic [3:0] len,
                            output logic [15:0] v, output bit o);
      int     l;
      int     cl;
      longint f;
      longint c;
      longint r;
      l = (int'(len) > 11) ? 11 : int'(len);
      f = longint'(imm) & ((longint'(1) << l) - 1);
      v = 16'h0000;
      o = 1'b0;
      if (m == 2'd3) begin
         mHave   = 1'b1;
         mPre    = f;
         mPreLen = l;
      end else begin
         if (mHave) begin
            c  = (mPre << l) | f;
            cl = mPreLen + l;
         end else begin
            c  = f;
            cl = l;
         end
         mHave   = 1'b0;
         mPre    = 0;
         mPreLen = 0;
         if (cl > 16) begin
            v = 16'(c);
            o = 1'b1;
         end else begin
            r = c;
            if ((m == 2'd1 || m == 2'd2) && cl > 0 && ((c >> (cl - 1)) & 1) == 1)
               r = c | ~((longint'(1) << cl) - 1);
            if (m == 2'd2)
               r = r << 1;
            v = 16'(r);
         end
      end
   endtask

   task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Entered and left at posedge+1. Holds the beat until the DUT takes it.
   task automatic applyStimulus(input logic [1:0] m, input logic [10:0] imm,
                                input logic [3:0] len, input bit useExp,
                                input logic [15:0] expVal, input bit expOvf,
                                input bit checkLat);
      int          waitCnt;
      bit          acc;
      logic [15:0] mv;
      bit          mo;
      exp_t        e;
      waitCnt  = 0;
      acc      = 1'b0;
      in_valid = 1'b1;
      mode     = m;
      imm_in   = imm;
      imm_len  = len;
      while (!acc) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
         end else begin
            waitCnt++;
            if (waitCnt > 200) begin
               checks++;
               errors++;
               $display("[TB] FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
               in_valid = 1'b0;
               return;
            end
            @(posedge clk);
            #1;
         end
      end
      modelStep(m, imm, len, mv, mo);
      if (m != 2'd3) begin
         e.val = useExp ? expVal : mv;
         e.ov  = useExp ? expOvf : mo;
         expQ.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (checkLat) begin
         @(negedge clk);
         expectEq("latency_out_valid", 32'(out_valid), 32'(m != 2'd3));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL unexpected_output: got %h ovf=%b, expected no result", imm_out, ovf);
      end else begin
         e = expQ.pop_front();
         if (imm_out !== e.val || ovf !== e.ov) begin
            errors++;
            $display("[TB] FAIL result: got %h ovf=%b, expected %h ovf=%b", imm_out, ovf, e.val, e.ov);
         end
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((expQ.size() != 0 || out_valid) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", expQ.size());
      end
   endtask

   initial begin
      logic [15:0] heldVal;
      bit          heldOvf;
      bit          heldValid;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      imm_in   = '0;
      imm_len  = '0;
      mode     = 2'd0;
      heldValid = 1'b0;
      heldVal   = '0;
      heldOvf   = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               heldValid = 1'b0;
            end else begin
`ifndef IMM_EXT_SKID_EN
               expectEq("in_ready_comb", 32'(in_ready), 32'(!out_valid || out_ready));
`endif
               if (out_valid) begin
                  if (heldValid) begin
                     expectEq("hold_value", {15'd0, heldOvf, heldVal}, {15'd0, ovf, imm_out});
                  end
                  if (out_ready) begin
                     checkOutput();
                     heldValid = 1'b0;
                  end else begin
                     heldValid = 1'b1;
                     heldVal   = imm_out;
                     heldOvf   = ovf;
                  end
               end else begin
                  heldValid = 1'b0;
               end
            end
         end
         begin
            #400000;
            errors++;
            $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      expectEq("reset_out_valid", 32'(out_valid), 32'd0);
      expectEq("reset_imm_out", 32'(imm_out), 32'd0);
      expectEq("reset_ovf", 32'(ovf), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      expectEq("in_ready_after_reset", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Directed vectors with one-cycle latency checks
      for (int i = 0; i < 18; i++) begin
         applyStimulus(dirTab[i].m, dirTab[i].imm, dirTab[i].len, 1'b1,
                       dirTab[i].v, dirTab[i].o, 1'b1);
      end
      waitDrain();

      // Back-pressure: output held for three cycles, then released
      fixReady = 1'b0;
      applyStimulus(2'd0, 11'h123, 4'd11, 1'b1, 16'h0123, 1'b0, 1'b0);
`ifdef IMM_EXT_SKID_EN
      applyStimulus(2'd0, 11'h055, 4'd7, 1'b1, 16'h0055, 1'b0, 1'b0);
`endif
      repeat (3) begin
         @(negedge clk);
         expectEq("stall_out_valid", 32'(out_valid), 32'd1);
         expectEq("stall_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      fixReady = 1'b1;
`ifndef IMM_EXT_SKID_EN
      applyStimulus(2'd0, 11'h055, 4'd7, 1'b1, 16'h0055, 1'b0, 1'b0);
`endif
      waitDrain();

      // Reset while a prefix is pending discards it
      applyStimulus(2'd3, 11'h03F, 4'd6, 1'b1, 16'h0000, 1'b0, 1'b0);
      rst_n = 1'b0;
      mHave   = 1'b0;
      mPre    = 0;
      mPreLen = 0;
      @(negedge clk);
      expectEq("midreset_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      expectEq("in_ready_after_midreset", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      applyStimulus(2'd1, 11'h0FF, 4'd8, 1'b1, 16'hFFFF, 1'b0, 1'b1);
      waitDrain();

      // Randomized traffic with random back-pressure
      randReady = 1'b1;
      for (int n = 0; n < 400; n++) begin
         logic [1:0]  rm;
         logic [10:0] ri;
         logic [3:0]  rl;
         rm = 2'($urandom_range(0, 3));
         ri = 11'($urandom);
         rl = 4'($urandom_range(0, 15));
         applyStimulus(rm, ri, rl, 1'b0, 16'h0000, 1'b0, 1'b0);
         if ($urandom_range(0, 3) == 0)
            idleCycles(1);
      end
      randReady = 1'b0;
      fixReady  = 1'b1;
      waitDrain();
      idleCycles(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
